// File: rtl/scr_test_sequencer.sv
// SCR detector test sequencer.
// Releases the detector pulse-forbid, fires a forward then a negative trigger
// pulse, waits for the detector to evaluate each one, then latches the
// breakdown/BOD flags and counts failing test cycles. All outputs are
// registered; i_forbid_req aborts to IDLE from any state.
module scr_test_sequencer #(
  parameter logic [19:0] PULSE_WIDTH = 20'd500,
  parameter logic [19:0] ARM_CYCLES  = 20'd50,
  parameter logic [19:0] WAIT_CYCLES = 20'd900100
) (
  input  logic       i_clk_50m,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_forbid_req,
  input  logic       i_fwd_state,
  input  logic       i_neg_state,
  input  logic       i_fwd_bod,
  input  logic       i_neg_bod,
  output logic       o_trig_forward,
  output logic       o_trig_negative,
  output logic       o_forbid,
  output logic       o_busy,
  output logic [3:0] o_result,
  output logic       o_result_valid,
  output logic [7:0] o_fail_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    FWD_PULSE,
    FWD_WAIT,
    NEG_PULSE,
    NEG_WAIT,
    REPORT
  } state_t;

  // Terminal counts; the phase counter runs from 0 to these values inclusive.
  localparam logic [19:0] ARM_LAST   = ARM_CYCLES - 20'd1;
  localparam logic [19:0] PULSE_LAST = PULSE_WIDTH - 20'd1;
  localparam logic [19:0] WAIT_LAST  = WAIT_CYCLES - 20'd1;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        trig_fwd_q, trig_fwd_d;
  logic        trig_neg_q, trig_neg_d;
  logic        forbid_q, forbid_d;
  logic        busy_q, busy_d;
  logic [3:0]  result_q, result_d;
  logic        valid_q, valid_d;
  logic [7:0]  fail_q, fail_d;
  logic [3:0]  sample;

  assign sample = {i_fwd_bod, i_neg_bod, i_fwd_state, i_neg_state};

  // Next-state, phase counter and result bookkeeping; outputs are decoded
  // from the next state so they come straight out of flops.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b1;
    result_d = result_q;
    valid_d  = 1'b0;
    fail_d   = fail_q;

    case (state_q)
      IDLE: begin
        cnt_d = 20'd0;
        // ready_q holds off the first edge after reset release.
        if (i_start && ready_q) state_d = ARM;
      end
      ARM: begin
        if (cnt_q == ARM_LAST) begin
          state_d = FWD_PULSE;
          cnt_d   = 20'd0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      // The counter keeps running from pulse rise through the wait phase so
      // the wait end is measured from the rising edge of the trigger.
      FWD_PULSE: begin
        cnt_d = cnt_q + 20'd1;
        if (cnt_q == PULSE_LAST) state_d = FWD_WAIT;
      end
      FWD_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = NEG_PULSE;
          cnt_d   = 20'd0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      NEG_PULSE: begin
        cnt_d = cnt_q + 20'd1;
        if (cnt_q == PULSE_LAST) state_d = NEG_WAIT;
      end
      NEG_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = REPORT;
          cnt_d   = 20'd0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      REPORT: begin
        cnt_d    = 20'd0;
        result_d = sample;
        valid_d  = 1'b1;
        if ((|sample) && (fail_q != 8'hFF)) fail_d = fail_q + 8'd1;
        // A stop request is only honoured here, at the cycle boundary.
        state_d = i_start ? FWD_PULSE : IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 20'd0;
      end
    endcase

    // Abort overrides every transition and discards any pending report.
    if (i_forbid_req) begin
      state_d  = IDLE;
      cnt_d    = 20'd0;
      result_d = result_q;
      valid_d  = 1'b0;
      fail_d   = fail_q;
    end

    trig_fwd_d = (state_d == FWD_PULSE);
    trig_neg_d = (state_d == NEG_PULSE);
    forbid_d   = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State and registered outputs; reset drops the triggers asynchronously.
  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 20'd0;
      ready_q    <= 1'b0;
      trig_fwd_q <= 1'b0;
      trig_neg_q <= 1'b0;
      forbid_q   <= 1'b1;
      busy_q     <= 1'b0;
      result_q   <= 4'b0000;
      valid_q    <= 1'b0;
      fail_q     <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      trig_fwd_q <= trig_fwd_d;
      trig_neg_q <= trig_neg_d;
      forbid_q   <= forbid_d;
      busy_q     <= busy_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      fail_q     <= fail_d;
    end
  end

  assign o_trig_forward  = trig_fwd_q;
  assign o_trig_negative = trig_neg_q;
  assign o_forbid        = forbid_q;
  assign o_busy          = busy_q;
  assign o_result        = result_q;
  assign o_result_valid  = valid_q;
  assign o_fail_cnt      = fail_q;

endmodule

// File: tb/tb_scr_test_sequencer.sv
// Testbench for scr_test_sequencer with short timing parameters.
// A timeline model (idle / arming / running with elapsed clocks since the
// forward rise) predicts every output each cycle; directed scenarios add
// literal expectations for timing, abort, reset and saturation.
module tb_scr_test_sequencer;

  localparam int P = 4;   // pulse width
  localparam int A = 3;   // arm clocks
  localparam int W = 20;  // rise-to-phase-end clocks
  localparam int CYCLE_LEN = 2 * W + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       fbd = 1'b0;
  logic [3:0] flags = 4'b0000;  // {fwd_bod, neg_bod, fwd_state, neg_state}

  logic       fwd, neg, forbid, busy, valid;
  logic [3:0] result;
  logic [7:0] fail;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  scr_test_sequencer #(
    .PULSE_WIDTH(20'd4),
    .ARM_CYCLES (20'd3),
    .WAIT_CYCLES(20'd20)
  ) dut (
    .i_clk_50m      (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_forbid_req   (fbd),
    .i_fwd_state    (flags[1]),
    .i_neg_state    (flags[0]),
    .i_fwd_bod      (flags[3]),
    .i_neg_bod      (flags[2]),
    .o_trig_forward (fwd),
    .o_trig_negative(neg),
    .o_forbid       (forbid),
    .o_busy         (busy),
    .o_result       (result),
    .o_result_valid (valid),
    .o_fail_cnt     (fail)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_ARM, M_RUN} mmode_t;
  mmode_t     m_mode = M_IDLE;
  int         m_t = 0;
  bit         m_ready = 1'b0;
  logic [3:0] m_result = 4'b0000;
  bit         m_valid = 1'b0;
  int         m_fail = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode   <= M_IDLE;
      m_t      <= 0;
      m_ready  <= 1'b0;
      m_result <= 4'b0000;
      m_valid  <= 1'b0;
      m_fail   <= 0;
    end else begin
      m_valid <= 1'b0;
      m_ready <= 1'b1;
      if (fbd) begin
        m_mode <= M_IDLE;
        m_t    <= 0;
      end else begin
        case (m_mode)
          M_IDLE: if (start && m_ready) begin m_mode <= M_ARM; m_t <= 0; end
          M_ARM:  if (m_t == A - 1) begin m_mode <= M_RUN; m_t <= 0; end
                  else m_t <= m_t + 1;
          M_RUN: begin
            if (m_t == 2 * W) begin
              m_result <= flags;
              m_valid  <= 1'b1;
              if (flags != 4'b0000 && m_fail < 255) m_fail <= m_fail + 1;
              if (start) m_t <= 0;
              else m_mode <= M_IDLE;
            end else begin
              m_t <= m_t + 1;
            end
          end
          default: m_mode <= M_IDLE;
        endcase
      end
    end
  end

  logic exp_fwd, exp_neg, exp_forbid, exp_busy;
  always_comb begin
    exp_fwd    = (m_mode == M_RUN) && (m_t < P);
    exp_neg    = (m_mode == M_RUN) && (m_t >= W) && (m_t < W + P);
    exp_forbid = (m_mode == M_IDLE);
    exp_busy   = (m_mode != M_IDLE);
  end

  // ---------------- compare + monitor ----------------
  int fwd_rises[$];
  int neg_rise_cnt = 0;
  int fwd_len = 0;
  int valid_cnt = 0;
  logic fwd_p = 1'b0, neg_p = 1'b0;

  always @(posedge clk) begin
    #1;
    check("trig", {30'd0, fwd, neg}, {30'd0, exp_fwd, exp_neg});
    check("trig_excl", {31'd0, fwd & neg}, 32'd0);
    check("forbid_busy", {30'd0, forbid, busy}, {30'd0, exp_forbid, exp_busy});
    check("result_valid", {27'd0, result, valid}, {27'd0, m_result, m_valid});
    check("fail_cnt", {24'd0, fail}, m_fail);
    if (fwd && !fwd_p) begin fwd_rises.push_back(cyc); fwd_len = 0; end
    if (fwd) fwd_len++;
    if (neg && !neg_p) neg_rise_cnt++;
    if (valid) valid_cnt++;
    fwd_p = fwd;
    neg_p = neg;
  end

  // ---------------- bounded waits ----------------
  task automatic wait_valid(input int bound, output bit ok);
    int v0 = valid_cnt;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #2;
      if (valid_cnt > v0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #2;
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_fwd_rise(input int bound, output bit ok);
    int n0 = fwd_rises.size();
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #2;
      if (fwd_rises.size() > n0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_neg_rise(input int bound, output bit ok);
    int n0 = neg_rise_cnt;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #2;
      if (neg_rise_cnt > n0) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int s, n0, v0;

    // Reset state and start held across reset release.
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    check("reset_state", {15'd0, fwd, neg, forbid, busy, result, valid, fail},
          {15'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 8'd0});
    @(negedge clk); rst_n = 1'b1; start = 1'b1;
    @(posedge clk); #2;
    check("first_edge_idle", {31'd0, busy}, 32'd0);
    @(posedge clk); #2;
    check("second_edge_arm", {30'd0, busy, forbid}, {30'd0, 1'b1, 1'b0});
    @(negedge clk); start = 1'b0;
    wait_idle(100, ok); check("a_idle", {31'd0, ok}, 32'd1);

    // Single cycle with flags 0101.
    @(negedge clk); flags = 4'b0101; start = 1'b1; s = cyc + 1;
    @(negedge clk); start = 1'b0;
    wait_valid(100, ok); check("b_valid_seen", {31'd0, ok}, 32'd1);
    check("b_cycle_len", cyc - s, 44);
    check("b_fwd_rise", fwd_rises[$] - s, 3);
    check("b_fwd_width", fwd_len, P);
    check("b_result", {28'd0, result}, 32'h5);
    check("b_fail", {24'd0, fail}, 32'd1);
    @(posedge clk); #2;
    check("b_after", {30'd0, valid, busy}, 32'd0);

    // Passing cycle: result clears, count holds.
    @(negedge clk); flags = 4'b0000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_valid(100, ok); check("b2_valid_seen", {31'd0, ok}, 32'd1);
    check("b2_result_fail", {20'd0, result, fail}, {20'd0, 4'b0000, 8'd1});
    wait_idle(10, ok); check("b2_idle", {31'd0, ok}, 32'd1);

    // Stop requested mid-wait: cycle completes with one report.
    n0 = fwd_rises.size(); v0 = valid_cnt;
    @(negedge clk); start = 1'b1;
    wait_fwd_rise(20, ok); check("c_fwd_rise", {31'd0, ok}, 32'd1);
    repeat (10) @(negedge clk);
    start = 1'b0;
    wait_idle(100, ok); check("c_idle", {31'd0, ok}, 32'd1);
    check("c_one_valid", valid_cnt - v0, 1);
    check("c_one_pulse", fwd_rises.size() - n0, 1);

    // Abort during negative pulse; forbid and start together stay idle.
    @(negedge clk); flags = 4'b1111; start = 1'b1;
    wait_neg_rise(100, ok); check("d_neg_rise", {31'd0, ok}, 32'd1);
    v0 = valid_cnt;
    @(negedge clk); fbd = 1'b1;
    @(posedge clk); #2;
    check("d_abort", {15'd0, fwd, neg, forbid, busy, result, valid, fail},
          {15'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 8'd1});
    repeat (2) begin
      @(posedge clk); #2;
      check("d_hold_idle", {31'd0, busy}, 32'd0);
    end
    @(negedge clk); fbd = 1'b0; start = 1'b0;
    repeat (60) @(negedge clk);
    check("d_no_valid", valid_cnt - v0, 0);

    // Asynchronous reset in the middle of the forward pulse.
    @(negedge clk); start = 1'b1;
    wait_fwd_rise(20, ok); check("e_fwd_rise", {31'd0, ok}, 32'd1);
    @(negedge clk); rst_n = 1'b0; start = 1'b0;
    #1;
    check("e_async_reset", {15'd0, fwd, neg, forbid, busy, result, valid, fail},
          {15'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 8'd0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_valid(100, ok); check("e_restart", {31'd0, ok}, 32'd1);
    check("e_result_fail", {20'd0, result, fail}, {20'd0, 4'b1111, 8'd1});
    wait_idle(10, ok); check("e_idle", {31'd0, ok}, 32'd1);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 9) != 0);
      fbd   = ($urandom_range(0, 149) == 0);
      flags = 4'($urandom_range(0, 15));
    end
    @(negedge clk); start = 1'b0; fbd = 1'b0;
    wait_idle(100, ok); check("g_idle", {31'd0, ok}, 32'd1);

    // Continuous failing cycles: back-to-back spacing and saturation.
    n0 = fwd_rises.size(); v0 = valid_cnt; ok = 1'b0;
    @(negedge clk); start = 1'b1;
    for (int i = 0; i < 301 * CYCLE_LEN + 200; i++) begin
      @(negedge clk);
      flags = 4'($urandom_range(1, 15));
      if (valid_cnt - v0 >= 300) begin ok = 1'b1; break; end
    end
    check("f_300_reports", {31'd0, ok}, 32'd1);
    start = 1'b0;
    wait_idle(100, ok); check("f_idle", {31'd0, ok}, 32'd1);
    for (int i = n0 + 1; i < fwd_rises.size(); i++)
      check("f_rise_spacing", fwd_rises[i] - fwd_rises[i-1], CYCLE_LEN);
    check("f_fail_sat", {24'd0, fail}, 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #4ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/scr_test_sequencer.md
SCR_TEST_SEQUENCER -- requirements
Module: scr_test_sequencer

Interface
REQ-001 The block SHALL have parameter PULSE_WIDTH, default 20'd500, giving the trigger pulse high time in clocks (10 us).
REQ-002 The block SHALL have parameter ARM_CYCLES, default 20'd50, giving the forbid-release settle time in clocks before the first pulse.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 20'd900100, giving the clocks from pulse rise to end of each phase; it SHALL exceed the detector evaluation point (900002).
REQ-004 i_clk_50m  in  1  the single 50 MHz clock; all logic SHALL be on its rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous and active-low.
REQ-006 i_start  in  1  level; 1 runs test cycles continuously, 0 stops at the next cycle boundary.
REQ-007 i_forbid_req  in  1  level; 1 aborts immediately.
REQ-008 i_fwd_state, i_neg_state, i_fwd_bod, i_neg_bod  in  1 each  detector breakdown and BOD flags, 1 = action.
REQ-009 o_trig_forward  out  1  forward trigger pulse to the detector.
REQ-010 o_trig_negative  out  1  negative trigger pulse to the detector.
REQ-011 o_forbid  out  1  detector pulse-forbid, 1 = forbidden.
REQ-012 o_busy  out  1  1 in any state other than IDLE.
REQ-013 o_result  out  4  latched {fwd_bod, neg_bod, fwd_state, neg_state}.
REQ-014 o_result_valid  out  1  one-clock strobe marking a new o_result.
REQ-015 o_fail_cnt  out  8  count of cycles with any result bit set; saturates at 255.

Function
REQ-016 The FSM SHALL have states IDLE, ARM, FWD_PULSE, FWD_WAIT, NEG_PULSE, NEG_WAIT, REPORT, with one shared 20-bit phase counter.
REQ-017 IDLE: o_forbid=1, triggers=0; i_start=1 and i_forbid_req=0 SHALL give ARM on the next clock with counter=0.
REQ-018 ARM: o_forbid=0; after ARM_CYCLES clocks in ARM the FSM SHALL go to FWD_PULSE.
REQ-019 FWD_PULSE: o_trig_forward=1 for exactly PULSE_WIDTH clocks, then FWD_WAIT; the counter SHALL not reset between the two states.
REQ-020 FWD_WAIT: when the counter reaches WAIT_CYCLES-1, FSM SHALL go to NEG_PULSE and the counter SHALL clear.
REQ-021 NEG_PULSE and NEG_WAIT SHALL mirror REQ-019 and REQ-020 using o_trig_negative; the NEG_WAIT exit SHALL go to REPORT.
REQ-022 REPORT lasts one clock: o_result SHALL take {i_fwd_bod, i_neg_bod, i_fwd_state, i_neg_state}, and o_result_valid SHALL be 1 on the following clock.
REQ-023 In REPORT, o_fail_cnt SHALL increment by 1 if any sampled bit is 1, and SHALL hold at 255.
REQ-024 After REPORT: i_start=1 SHALL give FWD_PULSE with no ARM; i_start=0 SHALL give IDLE.
REQ-025 Triggers SHALL be registered outputs, never both high, and each SHALL be low at least WAIT_CYCLES-PULSE_WIDTH clocks between pulses.
REQ-026 i_start falling mid-cycle SHALL NOT shorten the cycle; the stop takes effect only in REPORT.
REQ-027 i_forbid_req=1 in any state SHALL, on the next clock, give IDLE with triggers=0, o_forbid=1, counter=0, no REPORT and no o_result_valid; it SHALL have priority over all other transitions.
REQ-028 i_forbid_req and i_start both high in IDLE SHALL keep the FSM in IDLE.
REQ-029 o_result and o_fail_cnt SHALL hold their values through IDLE and abort, and change only in REPORT.

Reset
REQ-030 With i_rst_n=0, all outputs SHALL be forced asynchronously to their reset values: state=IDLE, counter=0, o_forbid=1, triggers=0, o_busy=0, o_result=4'b0000, o_result_valid=0, o_fail_cnt=0.
REQ-031 Reset asserted mid-pulse SHALL drop the active trigger within the same clock cycle, without waiting for an edge.
REQ-032 After i_rst_n deasserts, the FSM SHALL leave IDLE no earlier than the second rising edge.

Verification (PULSE_WIDTH=4, ARM_CYCLES=3, WAIT_CYCLES=20)
REQ-033 Single cycle: start for 1 clock -> o_forbid low; fwd high 4 clocks starting 3 clocks later; neg high 4 clocks, rising 20 clocks after fwd rise; valid 1 clock; o_busy=0 after; 44-45 clocks total.
REQ-034 Detector flags held 4'b0101 -> o_result=4'b0101, o_fail_cnt=1; flags at 0 on next cycle -> o_result=0000, count stays 1.
REQ-035 Continuous start -> back-to-back cycles with no ARM between; fwd rise exactly 41 clocks apart; 300 failing cycles -> o_fail_cnt=255.
REQ-036 i_forbid_req pulsed during NEG_PULSE -> next clock IDLE, o_trig_negative=0, o_forbid=1, no valid; o_result unchanged.
REQ-037 i_rst_n low during FWD_PULSE -> o_trig_forward=0 before the next edge, all outputs at reset values; release -> restarts from IDLE.
REQ-038 i_start deasserted during FWD_WAIT -> the cycle completes, one valid strobe, then IDLE.
